// File: rtl/cpu_stage_sequencer.sv
// Multi-cycle CPU stage sequencer: steps through N_STAGES stages, stalls memory stages on
// mem_ack, and supports halt at instruction boundaries, single-step, and retire/cycle counters.
module cpu_stage_sequencer #(
  parameter int unsigned          N_STAGES        = 5,
  parameter int unsigned          STAGE_W         = 3,
  parameter int unsigned          FETCH_STAGE     = 0,
  parameter int unsigned          PC_UPDATE_STAGE = 4,
  parameter logic [N_STAGES-1:0]  MEM_STAGE_MASK  = 5'b00101,
  parameter int unsigned          CNT_W           = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_ack,
  input  logic                halt_req,
  input  logic                step_mode,
  input  logic                step,
  output logic [STAGE_W-1:0]  stage,
  output logic [N_STAGES-1:0] stage_onehot,
  output logic                mem_req,
  output logic                stage_advance,
  output logic                issue_en,
  output logic                pc_en,
  output logic                halted,
  output logic [CNT_W-1:0]    retired_count,
  output logic [CNT_W-1:0]    cycle_count
);

  typedef enum logic [1:0] {StRun, StHalted, StStepWait} state_e;

  state_e              state_q, state_d;
  logic [STAGE_W-1:0]  stage_q, stage_d;
  logic                halt_pend_q, halt_pend_d;
  logic [CNT_W-1:0]    retired_q, retired_d;
  logic [CNT_W-1:0]    cycle_q, cycle_d;

  logic run;
  logic is_mem;
  logic last_stage;
  logic boundary;

  always_comb begin
    // Gating with rst keeps every strobe low for the whole time reset is held.
    run           = rst && (state_q == StRun);
    is_mem        = MEM_STAGE_MASK[stage_q];
    last_stage    = (stage_q == STAGE_W'(N_STAGES - 1));
    mem_req       = run && is_mem;
    stage_advance = run && (!is_mem || mem_ack);
    issue_en      = stage_advance && (stage_q == STAGE_W'(FETCH_STAGE));
    pc_en         = stage_advance && (stage_q == STAGE_W'(PC_UPDATE_STAGE));
    halted        = rst && (state_q != StRun);
    boundary      = stage_advance && last_stage;
    stage         = stage_q;
    retired_count = retired_q;
    cycle_count   = cycle_q;
  end

  always_comb begin
    stage_onehot = '0;
    for (int unsigned i = 0; i < N_STAGES; i++) begin
      stage_onehot[i] = run && (stage_q == STAGE_W'(i));
    end
  end

  always_comb begin
    state_d     = state_q;
    stage_d     = stage_q;
    halt_pend_d = halt_pend_q;
    retired_d   = retired_q;
    cycle_d     = cycle_q;
    unique case (state_q)
      StRun: begin
        cycle_d = cycle_q + CNT_W'(1);
        if (halt_req) halt_pend_d = 1'b1;
        if (stage_advance) stage_d = last_stage ? '0 : stage_q + STAGE_W'(1);
        if (boundary) begin
          retired_d = retired_q + CNT_W'(1);
          if (halt_pend_q || halt_req) begin
            state_d     = StHalted;
            halt_pend_d = 1'b0;
          end else if (step_mode) begin
            state_d = StStepWait;
          end
        end
      end
      StHalted: begin
        stage_d = '0;
        if (!halt_req) state_d = step_mode ? StStepWait : StRun;
      end
      StStepWait: begin
        stage_d = '0;
        if (halt_req) begin
          state_d     = StHalted;
          halt_pend_d = 1'b0;
        end else if (step || !step_mode) begin
          state_d = StRun;
        end
      end
      default: begin
        state_d     = StRun;
        stage_d     = '0;
        halt_pend_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StRun;
      stage_q     <= '0;
      halt_pend_q <= 1'b0;
      retired_q   <= '0;
      cycle_q     <= '0;
    end else begin
      state_q     <= state_d;
      stage_q     <= stage_d;
      halt_pend_q <= halt_pend_d;
      retired_q   <= retired_d;
      cycle_q     <= cycle_d;
    end
  end

endmodule

// File: tb/tb_cpu_stage_sequencer.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized
// stimulus compared every cycle against a behavioural model of the sequencer.
module tb_cpu_stage_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Main instance, default parameters.
  logic        mem_ack, halt_req, step_mode, step;
  logic [2:0]  stage;
  logic [4:0]  stage_onehot;
  logic        mem_req, stage_advance, issue_en, pc_en, halted;
  logic [31:0] retired_count, cycle_count;

  // Legacy instance: no memory stages.
  logic        leg_ack, leg_step;
  logic [2:0]  l_stage;
  logic [4:0]  l_onehot;
  logic        l_req, l_adv, l_issue, l_pc, l_halted;
  logic [31:0] l_ret, l_cyc;

  // Small wrap instance: 3 stages, 4-bit counters.
  logic [1:0]  w_stage;
  logic [2:0]  w_onehot;
  logic        w_req, w_adv, w_issue, w_pc, w_halted;
  logic [3:0]  w_ret, w_cyc;

  cpu_stage_sequencer dut (
    .clk(clk), .rst(rst), .mem_ack(mem_ack), .halt_req(halt_req), .step_mode(step_mode),
    .step(step), .stage(stage), .stage_onehot(stage_onehot), .mem_req(mem_req),
    .stage_advance(stage_advance), .issue_en(issue_en), .pc_en(pc_en), .halted(halted),
    .retired_count(retired_count), .cycle_count(cycle_count)
  );

  cpu_stage_sequencer #(.MEM_STAGE_MASK(5'b00000)) dut_leg (
    .clk(clk), .rst(rst), .mem_ack(leg_ack), .halt_req(1'b0), .step_mode(1'b0),
    .step(leg_step), .stage(l_stage), .stage_onehot(l_onehot), .mem_req(l_req),
    .stage_advance(l_adv), .issue_en(l_issue), .pc_en(l_pc), .halted(l_halted),
    .retired_count(l_ret), .cycle_count(l_cyc)
  );

  cpu_stage_sequencer #(
    .N_STAGES(3), .STAGE_W(2), .FETCH_STAGE(0), .PC_UPDATE_STAGE(2),
    .MEM_STAGE_MASK(3'b000), .CNT_W(4)
  ) dut_w (
    .clk(clk), .rst(rst), .mem_ack(leg_ack), .halt_req(1'b0), .step_mode(1'b0),
    .step(leg_step), .stage(w_stage), .stage_onehot(w_onehot), .mem_req(w_req),
    .stage_advance(w_adv), .issue_en(w_issue), .pc_en(w_pc), .halted(w_halted),
    .retired_count(w_ret), .cycle_count(w_cyc)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model of the main instance: mode 0 = running, 1 = halted, 2 = waiting for step.
  localparam logic [4:0] MASK = 5'b00101;
  int          m_mode;
  int          m_stage;
  bit          m_pend;
  bit          m_adv;
  int unsigned m_ret, m_cyc;
  int          leg_cyc;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_mode = 0; m_stage = 0; m_pend = 0; m_ret = 0; m_cyc = 0; leg_cyc = 0;
    end else begin
      leg_cyc++;
      if (m_mode == 0) begin
        m_cyc++;
        m_adv = !MASK[m_stage] || mem_ack;
        if (m_adv && m_stage == 4) begin
          m_ret++;
          m_stage = 0;
          if (m_pend || halt_req) begin
            m_mode = 1;
            m_pend = 0;
          end else if (step_mode) begin
            m_mode = 2;
          end
        end else begin
          if (m_adv) m_stage++;
          if (halt_req) m_pend = 1;
        end
      end else if (m_mode == 1) begin
        if (!halt_req) m_mode = step_mode ? 2 : 0;
      end else begin
        if (halt_req) m_mode = 1;
        else if (step || !step_mode) m_mode = 0;
      end
    end
  end

  bit e_run, e_adv;
  int l_st, w_st;

  always @(negedge clk) begin
    e_run = rst && (m_mode == 0);
    e_adv = e_run && (!MASK[m_stage] || mem_ack);
    chk("stage", stage, m_stage);
    chk("onehot", stage_onehot, e_run ? (1 << m_stage) : 0);
    chk("mem_req", mem_req, e_run && MASK[m_stage]);
    chk("advance", stage_advance, e_adv);
    chk("issue_en", issue_en, e_adv && m_stage == 0);
    chk("pc_en", pc_en, e_adv && m_stage == 4);
    chk("halted", halted, rst && m_mode != 0);
    chk("retired", retired_count, m_ret);
    chk("cycles", cycle_count, m_cyc);
    // Legacy instances are plain modulo counters of cycles since reset release.
    l_st = leg_cyc % 5;
    chk("leg_stage", l_stage, l_st);
    chk("leg_onehot", l_onehot, rst ? (1 << l_st) : 0);
    chk("leg_req", l_req, 0);
    chk("leg_adv", l_adv, rst);
    chk("leg_issue", l_issue, rst && l_st == 0);
    chk("leg_pc", l_pc, rst && l_st == 4);
    chk("leg_halted", l_halted, 0);
    chk("leg_retired", l_ret, leg_cyc / 5);
    chk("leg_cycles", l_cyc, leg_cyc);
    w_st = leg_cyc % 3;
    chk("w_stage", w_stage, w_st);
    chk("w_onehot", w_onehot, rst ? (1 << w_st) : 0);
    chk("w_pc", w_pc, rst && w_st == 2);
    chk("w_issue", w_issue, rst && w_st == 0);
    chk("w_retired", w_ret, (leg_cyc / 3) % 16);
    chk("w_cycles", w_cyc, leg_cyc % 16);
  end

  task automatic do_reset();
    rst = 1'b0;
    mem_ack = 1'b0; halt_req = 1'b0; step_mode = 1'b0; step = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  int req_cnt, iss_cnt, hold;

  initial begin
    mem_ack = 1'b0; halt_req = 1'b0; step_mode = 1'b0; step = 1'b0;
    leg_ack = 1'b0; leg_step = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_onehot", stage_onehot, 0);
    chk("rst_halted", halted, 0);
    rst = 1'b1;
    #1;
    chk("rel_onehot", stage_onehot, 5'b00001);
    chk("rel_mem_req", mem_req, 1);
    #(-1 + 1);

    // Memory wait, halt at boundary, legacy and wrap counts.
    req_cnt = 0; iss_cnt = 0;
    for (int c = 0; c <= 50; c++) begin
      mem_ack  = (c == 3) || (c == 5) || (c >= 8);
      halt_req = (c == 9) || (c >= 13 && c <= 17);
      leg_ack  = 1'($urandom);
      leg_step = 1'($urandom);
      step     = 1'($urandom);
      #2;
      if (c < 4) begin
        req_cnt += int'(mem_req);
        chk("mem_stage0_hold", stage, 0);
      end
      if (c < 8) iss_cnt += int'(issue_en);
      if (c == 4) begin
        chk("mem_req_cycles", req_cnt, 4);
        chk("mem_stage_after", stage, 1);
      end
      if (c == 7) chk("instr_not_done", retired_count, 0);
      if (c == 8) begin
        chk("instr_8_cycles", retired_count, 1);
        chk("issue_once", iss_cnt, 1);
      end
      // One instruction already retired before the halted one.
      if (c == 13 || c == 17) begin
        chk("halt_halted", halted, 1);
        chk("halt_stage", stage, 0);
        chk("halt_retired", retired_count, 2);
        chk("halt_cycles_frozen", cycle_count, 13);
      end
      if (c == 19) begin
        chk("resume_halted", halted, 0);
        chk("resume_onehot", stage_onehot, 5'b00001);
        chk("resume_cycles", cycle_count, 13);
      end
      if (c == 20) begin
        chk("legacy_retired20", l_ret, 4);
        chk("legacy_cycles20", l_cyc, 20);
      end
      if (c == 47) chk("wrap_retired47", w_ret, 15);
      if (c == 48) begin
        chk("wrap_retired48", w_ret, 0);
        chk("wrap_cycles48", w_cyc, 0);
      end
      @(posedge clk);
      #1;
    end

    // Single-step.
    do_reset();
    for (int c = 0; c <= 45; c++) begin
      step_mode = 1'b1;
      mem_ack   = 1'b1;
      step      = (c == 10) || (c == 12) || (c == 20) || (c == 30) || (c == 42);
      halt_req  = (c == 42);
      #2;
      if (c == 5) begin
        chk("step_wait_halted", halted, 1);
        chk("step_first_retired", retired_count, 1);
      end
      if (c == 11) begin
        chk("step_run", halted, 0);
        chk("step_run_stage", stage, 0);
      end
      if (c == 16) chk("step_in_run_ignored", retired_count, 2);
      if (c == 40) begin
        chk("step_three_retired", retired_count, 4);
        chk("step_three_halted", halted, 1);
      end
      if (c == 43) chk("halt_beats_step", halted, 1);
      @(posedge clk);
      #1;
    end

    // Reset during a stage-2 memory wait.
    do_reset();
    for (int c = 0; c <= 3; c++) begin
      mem_ack = (c == 0);
      #2;
      if (c < 3) begin
        @(posedge clk);
        #1;
      end
    end
    chk("pre_rst_mem_req", mem_req, 1);
    chk("pre_rst_stage", stage, 2);
    chk("pre_rst_cycles", cycle_count, 3);
    rst = 1'b0;
    #1;
    chk("async_mem_req", mem_req, 0);
    chk("async_stage", stage, 0);
    chk("async_advance", stage_advance, 0);
    chk("async_onehot", stage_onehot, 0);
    chk("async_cycles", cycle_count, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    mem_ack = 1'b1;
    #1;
    chk("restart_onehot", stage_onehot, 5'b00001);
    chk("restart_cycles", cycle_count, 0);
    repeat (10) @(posedge clk);
    #1;

    // Randomized operation against the model.
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      mem_ack  = ($urandom_range(0, 2) != 0);
      step     = ($urandom_range(0, 7) == 0);
      leg_ack  = 1'($urandom);
      leg_step = 1'($urandom);
      if (hold > 0) begin
        halt_req = 1'b1;
        hold--;
      end else if ($urandom_range(0, 40) == 0) begin
        halt_req = 1'b1;
        hold = $urandom_range(0, 12);
      end else begin
        halt_req = 1'b0;
      end
      if ($urandom_range(0, 99) == 0) step_mode = ~step_mode;
      if (i == 1500) begin
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
      end
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
